sensor_conditioner: RTL and testbench

//  Upstream input stage of the irrigation controller. Takes raw board switches and sensors
//  (soil humidity Us, level/type selects Bs/Vs, fertiliser request Adub, tank sensor T1).

---
 rtl/sensor_conditioner_pkg.sv | 24 ++
 rtl/sensor_conditioner_debounce_ch.sv | 61 ++++++
 rtl/sensor_conditioner.sv | 123 ++++++++++++
 tb/tb_sensor_conditioner.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sensor_conditioner_pkg.sv
// Shared definitions for the irrigation controller input stage.
// Holds the channel count, the channel index map used to pack the raw
// sensor/switch inputs into a vector, the debounce lengths for simulation
// and for the 50 MHz board build, and the Bs/Vs legality helper.
package sensor_conditioner_pkg;

  localparam int NUM_IN   = 5;

  localparam int IDX_US   = 0;
  localparam int IDX_BS   = 1;
  localparam int IDX_VS   = 2;
  localparam int IDX_ADUB = 3;
  localparam int IDX_T1   = 4;

  localparam int DEBOUNCE_CYCLES_SIM   = 16;
  localparam int DEBOUNCE_CYCLES_BOARD = 500000;

  // Bs/Vs both high is the one selector combination the downstream logic
  // cannot act on.
  function automatic logic pair_is_legal(input logic bs, input logic vs);
    return !(bs && vs);
  endfunction

endpackage

// File: rtl/sensor_conditioner_debounce_ch.sv
// One input channel: 2-flop synchroniser followed by a saturating debounce
// counter and the stable level.
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   raw_i          raw asynchronous input
//   stable_next_o  next-state of the stable level (valid in the cycle the
//                  stable level is about to update), so the parent can
//                  register derived outputs in the same cycle as the level.
module debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_next_o
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Debounce next-state: any return to the stable value restarts the count;
  // the level only flips after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q < CNT_TERM) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      stable_d = sync2_q;
      cnt_d    = {CNT_W{1'b0}};
    end
  end

  // Synchroniser, counter and stable level registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_next_o = stable_d;

endmodule

// File: rtl/sensor_conditioner.sv
// Input stage of the irrigation controller: synchronises and debounces the
// five raw board inputs, validates the Bs/Vs selector pair and flags changes.
// Ports:
//   Clk, Rst                     clock, synchronous active-high reset
//   Us_raw..T1_raw               raw asynchronous sensor/switch inputs
//   Us, Adub, T1                 debounced levels
//   Bs, Vs                       debounced levels, held at the last legal
//                                pair while the pair is 11
//   Err                          high while the debounced pair is 11
//   Chg                          one-cycle pulse after any of Us/Bs/Vs/Adub/T1
//                                changes
module sensor_conditioner
  import sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Us_raw,
  input  logic Bs_raw,
  input  logic Vs_raw,
  input  logic Adub_raw,
  input  logic T1_raw,
  output logic Us,
  output logic Bs,
  output logic Vs,
  output logic Adub,
  output logic T1,
  output logic Err,
  output logic Chg
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_IN-1:0] raw_s;
  logic [NUM_IN-1:0] stable_next_s;

  logic              us_q,   us_d;
  logic              bs_q,   bs_d;
  logic              vs_q,   vs_d;
  logic              adub_q, adub_d;
  logic              t1_q,   t1_d;
  logic              err_q,  err_d;
  logic              chg_q,  chg_d;
  logic [NUM_IN-1:0] out_s;
  logic [NUM_IN-1:0] prev_q;

  assign raw_s[IDX_US]   = Us_raw;
  assign raw_s[IDX_BS]   = Bs_raw;
  assign raw_s[IDX_VS]   = Vs_raw;
  assign raw_s[IDX_ADUB] = Adub_raw;
  assign raw_s[IDX_T1]   = T1_raw;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce_ch (
      .clk_i         (Clk),
      .rst_i         (Rst),
      .raw_i         (raw_s[g]),
      .stable_next_o (stable_next_s[g])
    );
  end

  // Output next-state. The plain channels copy the channel's next stable
  // level, so these flops always equal the channel's stable level. Bs/Vs are
  // validated on the next stable pair so they move in the same cycle as it.
  always_comb begin
    us_d   = stable_next_s[IDX_US];
    adub_d = stable_next_s[IDX_ADUB];
    t1_d   = stable_next_s[IDX_T1];
    if (pair_is_legal(stable_next_s[IDX_BS], stable_next_s[IDX_VS])) begin
      bs_d  = stable_next_s[IDX_BS];
      vs_d  = stable_next_s[IDX_VS];
      err_d = 1'b0;
    end else begin
      bs_d  = bs_q;
      vs_d  = vs_q;
      err_d = 1'b1;
    end
  end

  assign out_s = {t1_q, adub_q, vs_q, bs_q, us_q};

  // Change detector compares the visible outputs against last cycle's copy;
  // Err is deliberately not part of the compared vector.
  always_comb begin
    chg_d = (out_s != prev_q);
  end

  // Output, previous-value and change-pulse registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      us_q   <= 1'b0;
      bs_q   <= 1'b0;
      vs_q   <= 1'b0;
      adub_q <= 1'b0;
      t1_q   <= 1'b0;
      err_q  <= 1'b0;
      chg_q  <= 1'b0;
      prev_q <= {NUM_IN{1'b0}};
    end else begin
      us_q   <= us_d;
      bs_q   <= bs_d;
      vs_q   <= vs_d;
      adub_q <= adub_d;
      t1_q   <= t1_d;
      err_q  <= err_d;
      chg_q  <= chg_d;
      prev_q <= out_s;
    end
  end

  assign Us   = us_q;
  assign Bs   = bs_q;
  assign Vs   = vs_q;
  assign Adub = adub_q;
  assign T1   = t1_q;
  assign Err  = err_q;
  assign Chg  = chg_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner with DEBOUNCE_CYCLES=4.
// The stimulus process pushes the expected output vector and the cycle on
// which the Chg pulse must appear; the monitor pops on every Chg pulse.
module tb_sensor_conditioner;

  localparam int DC = 4;

  logic Clk = 1'b0;
  logic Rst;
  logic Us_raw, Bs_raw, Vs_raw, Adub_raw, T1_raw;
  logic Us, Bs, Vs, Adub, T1, Err, Chg;

  typedef struct {
    int         cyc;
    logic [5:0] val;   // {Us,Bs,Vs,Adub,T1,Err}
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  sensor_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Us_raw   (Us_raw),
    .Bs_raw   (Bs_raw),
    .Vs_raw   (Vs_raw),
    .Adub_raw (Adub_raw),
    .T1_raw   (T1_raw),
    .Us       (Us),
    .Bs       (Bs),
    .Vs       (Vs),
    .Adub     (Adub),
    .T1       (T1),
    .Err      (Err),
    .Chg      (Chg)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [5:0] outs();
    return {Us, Bs, Vs, Adub, T1, Err};
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Raw change applied at this negedge: first sampling edge is cyc+1, the
  // stable level flips on edge cyc+DC+2, Chg is visible after edge cyc+DC+3.
  task automatic expect_chg(input logic [5:0] v);
    exp_t e;
    e.cyc = cyc + DC + 3;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Monitor: every Chg pulse must match the next queued expectation.
  always @(negedge Clk) begin
    if (Chg === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL chg_unexpected: got pulse with outs %b, expected none (cyc %0d)", outs(), cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.cyc != cyc || outs() !== e.val) begin
          errors++;
          $display("FAIL chg_pulse: got cyc %0d outs %b expected cyc %0d outs %b",
                   cyc, outs(), e.cyc, e.val);
        end
      end
    end
  end

  initial begin
    Rst = 1'b1;
    {Us_raw, Bs_raw, Vs_raw, Adub_raw, T1_raw} = 5'b11111;
    step(2);
    chk("reset_outs", outs(), 6'b000000);
    chk("reset_chg", {5'b0, Chg}, 6'b000000);
    {Us_raw, Bs_raw, Vs_raw, Adub_raw, T1_raw} = 5'b00000;
    step(2);
    Rst = 1'b0;
    step(10);
    chk("idle_outs", outs(), 6'b000000);

    // Us step: exact latency
    Us_raw = 1'b1;
    expect_chg(6'b100000);
    step(DC + 1);
    chk("us_before", {5'b0, Us}, 6'b000000);
    step(1);
    chk("us_after", {5'b0, Us}, 6'b000001);
    step(6);

    // Adub: short pulses with a bounce must never reach the output
    Adub_raw = 1'b1;
    step(DC - 1);
    Adub_raw = 1'b0;
    step(1);
    Adub_raw = 1'b1;
    step(DC - 1);
    Adub_raw = 1'b0;
    step(DC + 4);
    chk("adub_filtered", {5'b0, Adub}, 6'b000000);

    // Bs settles, then Vs makes the pair illegal
    Bs_raw = 1'b1;
    expect_chg(6'b110000);
    step(DC + 6);
    chk("bs_set", outs(), 6'b110000);
    Vs_raw = 1'b1;
    step(DC + 1);
    chk("err_before", {5'b0, Err}, 6'b000000);
    step(1);
    chk("illegal_hold", outs(), 6'b110001);
    step(6);
    chk("illegal_steady", outs(), 6'b110001);

    // Pair returns legal as 01
    Bs_raw = 1'b0;
    expect_chg(6'b101000);
    step(DC + 1);
    chk("err_still", {5'b0, Err}, 6'b000001);
    step(1);
    chk("legal_return", outs(), 6'b101000);
    step(6);

    // T1 held, reset pulsed at count 2
    T1_raw = 1'b1;
    step(4);
    Rst = 1'b1;
    step(1);
    chk("rst_mid_outs", outs(), 6'b000000);
    Rst = 1'b0;
    expect_chg(6'b101010);
    step(DC + 1);
    chk("t1_after_rst_low", {5'b0, T1}, 6'b000000);
    step(1);
    chk("t1_after_rst_high", outs(), 6'b101010);
    step(6);

    // Us and T1 fall together, then rise together: one pulse each
    Us_raw = 1'b0;
    T1_raw = 1'b0;
    expect_chg(6'b001000);
    step(DC + 6);
    chk("both_low", outs(), 6'b001000);
    Us_raw = 1'b1;
    T1_raw = 1'b1;
    expect_chg(6'b101010);
    step(DC + 2);
    chk("both_high", outs(), 6'b101010);
    step(6);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending pulses expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
